// File: rtl/imem_dmem_arbiter_if.sv
// rtl/imem_dmem_arbiter_if.sv - fetch, load/store and memory port signals of the arbiter
// Purpose: bundles the three request/grant/response ports seen by imem_dmem_arbiter.
// Ports:
//   instr_* : fetch stage request/grant and response
//   data_*  : load/store unit request/grant and response
//   mem_*   : shared single memory port
//   resp_unexp_o : sticky flag for responses with no outstanding owner
// Modports: slave = arbiter view, master = environment (core + memory) view.
interface imem_dmem_arbiter_if;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        instr_err_o;

  logic        data_req_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        data_err_o;

  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        mem_err_i;

  logic        resp_unexp_o;

  modport slave (
    input  instr_req_i, instr_addr_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
    output resp_unexp_o
  );

  modport master (
    output instr_req_i, instr_addr_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
    input  resp_unexp_o
  );
endinterface

// File: rtl/imem_dmem_arbiter.sv
// rtl/imem_dmem_arbiter.sv - shares one req/gnt/rvalid memory port between fetch and load/store
// Purpose: data has priority over fetch, bounded by a starvation limit; a request that
//   is not granted immediately is locked until granted; an in-order owner FIFO routes
//   each response back to the requester that issued it.
// Ports:
//   clk  : clock, rising edge
//   rstn : asynchronous active-low reset
//   bus  : imem_dmem_arbiter_if.slave (fetch, load/store and memory ports)
module imem_dmem_arbiter #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  imem_dmem_arbiter_if.slave   bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOCK_I = 2'd1;
  localparam logic [1:0] ST_LOCK_D = 2'd2;

  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  localparam logic [PW-1:0] LAST_PTR   = PW'(MAX_OUTSTANDING - 1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(MAX_OUTSTANDING);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [1:0]                 state_q, state_d;
  logic [MAX_OUTSTANDING-1:0] owner_q, owner_d;
  logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]              count_q, count_d;
  logic [SW-1:0]              starve_cnt_q, starve_cnt_d;
  logic                       resp_unexp_q, resp_unexp_d;

  logic sel_data;
  logic sel_req;
  logic force_instr;
  logic fifo_empty;
  logic fifo_full;
  logic mem_req;
  logic grant;
  logic pop;
  logic head_owner;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Source selection: locked states only look at the locked source.
  always_comb begin
    sel_data    = 1'b0;
    sel_req     = 1'b0;
    force_instr = bus.instr_req_i && (starve_cnt_q == STARVE_MAX);
    case (state_q)
      ST_LOCK_I: begin
        sel_data = 1'b0;
        sel_req  = bus.instr_req_i;
      end
      ST_LOCK_D: begin
        sel_data = 1'b1;
        sel_req  = bus.data_req_i;
      end
      default: begin
        if (bus.data_req_i && !force_instr) begin
          sel_data = 1'b1;
          sel_req  = 1'b1;
        end else begin
          sel_data = 1'b0;
          sel_req  = bus.instr_req_i;
        end
      end
    endcase
  end

  // A response popping the head frees a slot in the same cycle, so a full FIFO
  // can still accept a grant when mem_rvalid_i is high.
  assign fifo_empty = (count_q == '0);
  assign pop        = bus.mem_rvalid_i && !fifo_empty;
  assign fifo_full  = (count_q == FULL_CNT) && !pop;
  assign mem_req    = sel_req && !fifo_full;
  assign grant      = mem_req && bus.mem_gnt_i;
  assign head_owner = owner_q[rd_ptr_q];

  always_comb begin
    bus.mem_req_o   = mem_req;
    bus.mem_we_o    = 1'b0;
    bus.mem_be_o    = 4'h0;
    bus.mem_addr_o  = 32'h0;
    bus.mem_wdata_o = 32'h0;
    if (sel_req) begin
      if (sel_data) begin
        bus.mem_we_o    = bus.data_we_i;
        bus.mem_be_o    = bus.data_be_i;
        bus.mem_addr_o  = bus.data_addr_i;
        bus.mem_wdata_o = bus.data_wdata_i;
      end else begin
        bus.mem_be_o    = 4'hF;
        bus.mem_addr_o  = bus.instr_addr_i;
      end
    end
  end

  assign bus.instr_gnt_o    = grant && !sel_data;
  assign bus.data_gnt_o     = grant && sel_data;
  assign bus.instr_rvalid_o = pop && !head_owner;
  assign bus.data_rvalid_o  = pop && head_owner;
  assign bus.instr_rdata_o  = bus.mem_rdata_i;
  assign bus.data_rdata_o   = bus.mem_rdata_i;
  assign bus.instr_err_o    = bus.mem_err_i;
  assign bus.data_err_o     = bus.mem_err_i;
  assign bus.resp_unexp_o   = resp_unexp_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_req && !bus.mem_gnt_i) state_d = sel_data ? ST_LOCK_D : ST_LOCK_I;
      end
      ST_LOCK_I, ST_LOCK_D: begin
        // A blocked-by-full FIFO keeps the lock; a withdrawn request releases it.
        if (!sel_req || grant) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    owner_d  = owner_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (grant) begin
      owner_d[wr_ptr_q] = sel_data;
      wr_ptr_d          = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({grant, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!bus.instr_req_i) begin
      starve_cnt_d = '0;
    end else if (grant && !sel_data) begin
      starve_cnt_d = '0;
    end else if (grant && sel_data && (starve_cnt_q != STARVE_MAX)) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  // A response can never belong to a grant made in the same cycle.
  assign resp_unexp_d = resp_unexp_q || (bus.mem_rvalid_i && fifo_empty);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      starve_cnt_q <= '0;
      resp_unexp_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      starve_cnt_q <= starve_cnt_d;
      resp_unexp_q <= resp_unexp_d;
    end
  end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// tb/tb_imem_dmem_arbiter.sv - self-checking bench for imem_dmem_arbiter
module tb_imem_dmem_arbiter;

  logic clk;
  logic rstn;

  imem_dmem_arbiter_if bif();

  imem_dmem_arbiter #(
    .MAX_OUTSTANDING (2),
    .STARVE_LIMIT    (4)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // {owner(1=data), err, rdata} in grant order
  logic [33:0] sb_q[$];
  // addresses accepted by the memory model, awaiting a response
  logic [31:0] pend_q[$];

  logic resp_en;
  logic extra_rsp;

  function automatic logic [31:0] rsp_data(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bif.instr_req_i = 1'b0;
    bif.data_req_i  = 1'b0;
    repeat (n) advance();
  endtask

  // Memory model: accepts on the grant cycle, answers in order one cycle later.
  always @(negedge clk) begin
    if (rstn && bif.mem_req_o && bif.mem_gnt_i) pend_q.push_back(bif.mem_addr_o);
  end

  always @(posedge clk) begin
    logic [31:0] a;
    #1;
    if (extra_rsp) begin
      bif.mem_rvalid_i = 1'b1;
      bif.mem_rdata_i  = 32'hDEAD_BEEF;
      bif.mem_err_i    = 1'b0;
    end else if (resp_en && pend_q.size() > 0) begin
      a = pend_q.pop_front();
      bif.mem_rvalid_i = 1'b1;
      bif.mem_rdata_i  = rsp_data(a);
      bif.mem_err_i    = a[2];
    end else begin
      bif.mem_rvalid_i = 1'b0;
      bif.mem_rdata_i  = 32'h0;
      bif.mem_err_i    = 1'b0;
    end
  end

  // Scoreboard: responses checked first, then this cycle's grants recorded.
  always @(negedge clk) begin
    logic [33:0] e;
    if (rstn) begin
      if (bif.instr_rvalid_o && bif.data_rvalid_o) check("rv_both", 1, 0);
      if (bif.instr_rvalid_o || bif.data_rvalid_o) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("rsp_owner", bif.data_rvalid_o, e[33]);
          check("rsp_err", bif.data_rvalid_o ? bif.data_err_o : bif.instr_err_o, e[32]);
          check("rsp_rdata", bif.data_rvalid_o ? bif.data_rdata_o : bif.instr_rdata_o, e[31:0]);
        end
      end
      if (bif.instr_gnt_o) sb_q.push_back({1'b0, bif.instr_addr_i[2], rsp_data(bif.instr_addr_i)});
      if (bif.data_gnt_o)  sb_q.push_back({1'b1, bif.data_addr_i[2],  rsp_data(bif.data_addr_i)});
    end
  end

  initial begin
    logic [31:0] a;
    rstn              = 1'b0;
    resp_en           = 1'b0;
    extra_rsp         = 1'b0;
    bif.instr_req_i   = 1'b0;
    bif.instr_addr_i  = 32'h0;
    bif.data_req_i    = 1'b0;
    bif.data_we_i     = 1'b0;
    bif.data_be_i     = 4'h0;
    bif.data_addr_i   = 32'h0;
    bif.data_wdata_i  = 32'h0;
    bif.mem_gnt_i     = 1'b0;
    bif.mem_rvalid_i  = 1'b0;
    bif.mem_rdata_i   = 32'h0;
    bif.mem_err_i     = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", bif.mem_req_o, 0);
    check("rst_mem_addr", bif.mem_addr_o, 0);
    check("rst_igant", bif.instr_gnt_o, 0);
    check("rst_dgnt", bif.data_gnt_o, 0);
    check("rst_unexp", bif.resp_unexp_o, 0);
    rstn = 1'b1;
    advance();

    // Fetch-only streaming, one grant and one response per cycle.
    bif.mem_gnt_i = 1'b1;
    resp_en       = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = 32'h1000_0000 + 32'(i * 4);
      bif.instr_req_i  = 1'b1;
      bif.instr_addr_i = a;
      @(negedge clk);
      check("t1_igant", bif.instr_gnt_o, 1);
      check("t1_dgnt", bif.data_gnt_o, 0);
      check("t1_addr", bif.mem_addr_o, a);
      check("t1_be", bif.mem_be_o, 4'hF);
      check("t1_we", bif.mem_we_o, 0);
      if (i > 0) check("t1_irv", bif.instr_rvalid_o, 1);
      check("t1_drv", bif.data_rvalid_o, 0);
      advance();
    end
    bif.instr_req_i = 1'b0;
    @(negedge clk);
    check("t1_irv_last", bif.instr_rvalid_o, 1);
    advance();
    idle(2);

    // Simultaneous requests: data first, fetch the next cycle.
    bif.instr_req_i  = 1'b1;
    bif.instr_addr_i = 32'h1000_0104;
    bif.data_req_i   = 1'b1;
    bif.data_we_i    = 1'b1;
    bif.data_be_i    = 4'h3;
    bif.data_addr_i  = 32'h2000_0010;
    bif.data_wdata_i = 32'h1234_5678;
    @(negedge clk);
    check("t2_dgnt", bif.data_gnt_o, 1);
    check("t2_igant", bif.instr_gnt_o, 0);
    check("t2_addr", bif.mem_addr_o, 32'h2000_0010);
    check("t2_we", bif.mem_we_o, 1);
    check("t2_be", bif.mem_be_o, 4'h3);
    check("t2_wdata", bif.mem_wdata_o, 32'h1234_5678);
    advance();
    bif.data_req_i = 1'b0;
    bif.data_we_i  = 1'b0;
    @(negedge clk);
    check("t2_igant_next", bif.instr_gnt_o, 1);
    check("t2_addr_next", bif.mem_addr_o, 32'h1000_0104);
    check("t2_wdata_next", bif.mem_wdata_o, 0);
    advance();
    idle(3);

    // Starvation: four data grants with fetch pending, then fetch is forced.
    bif.instr_req_i  = 1'b1;
    bif.instr_addr_i = 32'h1000_0200;
    bif.data_req_i   = 1'b1;
    bif.data_be_i    = 4'hF;
    for (int i = 0; i < 6; i++) begin
      bif.data_addr_i = 32'h2000_0100 + 32'(i * 4);
      @(negedge clk);
      if (i == 4) begin
        check("t3_forced_igant", bif.instr_gnt_o, 1);
        check("t3_forced_dgnt", bif.data_gnt_o, 0);
      end else begin
        check("t3_dgnt", bif.data_gnt_o, 1);
        check("t3_igant", bif.instr_gnt_o, 0);
      end
      advance();
      if (i == 4) bif.instr_addr_i = 32'h1000_0204;
    end
    idle(3);

    // Lock: fetch stalled three cycles, data raised in the third.
    bif.mem_gnt_i    = 1'b0;
    bif.instr_req_i  = 1'b1;
    bif.instr_addr_i = 32'h1000_0300;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        bif.data_req_i  = 1'b1;
        bif.data_addr_i = 32'h2000_0204;
      end
      @(negedge clk);
      check("t4_req", bif.mem_req_o, 1);
      check("t4_addr", bif.mem_addr_o, 32'h1000_0300);
      check("t4_igant", bif.instr_gnt_o, 0);
      check("t4_dgnt", bif.data_gnt_o, 0);
      advance();
    end
    bif.mem_gnt_i = 1'b1;
    @(negedge clk);
    check("t4_igant_rel", bif.instr_gnt_o, 1);
    check("t4_dgnt_rel", bif.data_gnt_o, 0);
    check("t4_addr_rel", bif.mem_addr_o, 32'h1000_0300);
    advance();
    bif.instr_req_i = 1'b0;
    @(negedge clk);
    check("t4_dgnt_after", bif.data_gnt_o, 1);
    check("t4_addr_after", bif.mem_addr_o, 32'h2000_0204);
    advance();
    idle(3);

    // Owner FIFO full: third request waits until a response frees a slot.
    resp_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bif.instr_req_i  = 1'b1;
      bif.instr_addr_i = 32'h1000_0400 + 32'(i * 4);
      @(negedge clk);
      check("t5_req", bif.mem_req_o, (i < 2) ? 1 : 0);
      check("t5_igant", bif.instr_gnt_o, (i < 2) ? 1 : 0);
      if (i == 2) resp_en = 1'b1;
      advance();
    end
    @(negedge clk);
    check("t5_igant_pop", bif.instr_gnt_o, 1);
    check("t5_irv_pop", bif.instr_rvalid_o, 1);
    resp_en = 1'b0;
    advance();
    bif.instr_addr_i = 32'h1000_040C;
    @(negedge clk);
    check("t5_still_full", bif.mem_req_o, 0);
    resp_en = 1'b1;
    advance();
    idle(4);

    // Response ordering I, D, I, then an unexpected response.
    bif.instr_req_i  = 1'b1;
    bif.instr_addr_i = 32'h1000_0500;
    @(negedge clk);
    check("t6_igant0", bif.instr_gnt_o, 1);
    advance();
    bif.instr_req_i = 1'b0;
    bif.data_req_i  = 1'b1;
    bif.data_addr_i = 32'h2000_0304;
    @(negedge clk);
    check("t6_dgnt", bif.data_gnt_o, 1);
    check("t6_irv0", bif.instr_rvalid_o, 1);
    advance();
    bif.data_req_i   = 1'b0;
    bif.instr_req_i  = 1'b1;
    bif.instr_addr_i = 32'h1000_0508;
    @(negedge clk);
    check("t6_igant1", bif.instr_gnt_o, 1);
    check("t6_drv", bif.data_rvalid_o, 1);
    check("t6_irv_off", bif.instr_rvalid_o, 0);
    advance();
    bif.instr_req_i = 1'b0;
    @(negedge clk);
    check("t6_irv1", bif.instr_rvalid_o, 1);
    extra_rsp = 1'b1;
    advance();
    @(negedge clk);
    check("t6_extra_irv", bif.instr_rvalid_o, 0);
    check("t6_extra_drv", bif.data_rvalid_o, 0);
    check("t6_unexp_pre", bif.resp_unexp_o, 0);
    extra_rsp = 1'b0;
    advance();
    @(negedge clk);
    check("t6_unexp_set", bif.resp_unexp_o, 1);
    advance();
    @(negedge clk);
    check("t6_unexp_hold", bif.resp_unexp_o, 1);
    check("sb_empty", sb_q.size(), 0);
    rstn = 1'b0;
    #1;
    check("t6_unexp_rst", bif.resp_unexp_o, 0);
    check("t6_req_rst", bif.mem_req_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
